// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: start control, instruction-memory port, redirect and decode handshake.
interface fetch_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              Start;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] InstructionIn;
  logic              BranchValid;
  logic [ADDR_W-1:0] BranchTarget;
  logic              InstrValid;
  logic              InstrReady;
  logic [DATA_W-1:0] InstrOut;
  logic [ADDR_W-1:0] PCOut;
  logic              Halted;
  logic [15:0]       FetchCount;

  modport master (
    input  Start, InstructionIn, BranchValid, BranchTarget, InstrReady,
    output Address, InstrValid, InstrOut, PCOut, Halted, FetchCount
  );

  modport slave (
    output Start, InstructionIn, BranchValid, BranchTarget, InstrReady,
    input  Address, InstrValid, InstrOut, PCOut, Halted, FetchCount
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Single-entry valid/ready holding register for the fetched {instruction, pc} pair.
module fetch_out_reg #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic         ready,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data_out,
  output logic         slot_free,
  output logic         xfer
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // flush wins over load so a redirect never lets a stale capture through
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    slot_free = !valid_q || ready;
    xfer      = valid_q && ready;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, branch redirect, halt detection and transfer count.
//   state    | meaning
//   ST_IDLE  | waiting for Start, redirects ignored
//   ST_FETCH | one capture per edge whenever the output slot is free
//   ST_HALT  | halt word captured, waiting for a redirect
module fetch_unit #(
  parameter int                ADDR_W    = fetch_pkg::ADDR_W_DEF,
  parameter int                DATA_W    = fetch_pkg::DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PC_STEP   = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(fetch_pkg::HALT_WORD)
) (
  input  logic         Clk,
  input  logic         Rst_n,
  fetch_unit_if.master bus
);

  fetch_pkg::state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       count_q, count_d;

  logic                     redirect;
  logic                     load;
  logic                     slot_free;
  logic                     xfer;
  logic                     out_valid;
  logic [DATA_W+ADDR_W-1:0] out_data;

  always_comb begin
    redirect = bus.BranchValid && (state_q != fetch_pkg::ST_IDLE);
    load     = (state_q == fetch_pkg::ST_FETCH) && slot_free && !redirect;
    state_d  = state_q;
    pc_d     = pc_q;
    // counted on the handshake itself, so a flushed-but-unaccepted entry never counts
    count_d  = xfer ? fetch_pkg::sat_inc16(count_q) : count_q;
    case (state_q)
      fetch_pkg::ST_IDLE: begin
        if (bus.Start) state_d = fetch_pkg::ST_FETCH;
      end
      fetch_pkg::ST_FETCH: begin
        if (redirect) begin
          pc_d = bus.BranchTarget;
        end else if (load) begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
          if (bus.InstructionIn == HALT_WORD) state_d = fetch_pkg::ST_HALT;
        end
      end
      fetch_pkg::ST_HALT: begin
        if (redirect) begin
          pc_d    = bus.BranchTarget;
          state_d = fetch_pkg::ST_FETCH;
        end
      end
      default: state_d = fetch_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= fetch_pkg::ST_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  fetch_out_reg #(.W(DATA_W + ADDR_W)) u_out_reg (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (load),
    .flush    (redirect),
    .ready    (bus.InstrReady),
    .data_in  ({bus.InstructionIn, pc_q}),
    .valid    (out_valid),
    .data_out (out_data),
    .slot_free(slot_free),
    .xfer     (xfer)
  );

  assign bus.Address    = pc_q;
  assign bus.InstrValid = out_valid;
  assign bus.InstrOut   = out_data[DATA_W+ADDR_W-1:ADDR_W];
  assign bus.PCOut      = out_data[ADDR_W-1:0];
  assign bus.Halted     = (state_q == fetch_pkg::ST_HALT);
  assign bus.FetchCount = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a combinational instruction-memory model.
module tb_fetch_unit;

  logic Clk = 1'b0;
  logic Rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  fetch_unit dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.master)
  );

  always #5 Clk = ~Clk;

  assign bus.InstructionIn = (bus.Address == 8'h06) ? 32'hFFFF_FFFF : {24'hA5A5A5, bus.Address};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; bus.Start = 1'b0; bus.BranchValid = 1'b0;
    bus.BranchTarget = 8'h00; bus.InstrReady = 1'b1;
    step(); step();
    checks++; if (bus.Address !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", bus.Address); end
    checks++; if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.InstrValid); end
    checks++; if (bus.InstrOut !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", bus.InstrOut); end
    checks++; if (bus.PCOut !== 8'h00) begin errors++; $display("FAIL rst_pcout: got %h want 00", bus.PCOut); end
    checks++; if (bus.Halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus.Halted); end
    checks++; if (bus.FetchCount !== 16'h0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.FetchCount); end
    Rst_n = 1'b1;
    bus.BranchValid = 1'b1; bus.BranchTarget = 8'h40;
    step();
    bus.BranchValid = 1'b0;
    checks++; if (bus.Address !== 8'h00) begin errors++; $display("FAIL idle_branch_ignored: addr %h want 00", bus.Address); end
    step();
    checks++; if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL idle_no_start: valid %b want 0", bus.InstrValid); end
  endtask

  task automatic test_stream();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    checks++; if (bus.InstrValid !== 1'b0 || bus.Address !== 8'h00) begin errors++;
      $display("FAIL start_edge: valid %b addr %h want 0/00", bus.InstrValid, bus.Address); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.InstrValid !== 1'b1 || bus.PCOut !== 8'(i) || bus.InstrOut !== {24'hA5A5A5, 8'(i)}) begin errors++;
        $display("FAIL stream_%0d: valid %b pc %h instr %h want 1/%h/%h", i, bus.InstrValid, bus.PCOut, bus.InstrOut, 8'(i), {24'hA5A5A5, 8'(i)}); end
      checks++; if (bus.FetchCount !== 16'(i)) begin errors++; $display("FAIL stream_count_%0d: got %0d want %0d", i, bus.FetchCount, i); end
    end
  endtask

  task automatic test_stall();
    bus.InstrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.PCOut !== 8'h02 || bus.InstrOut !== 32'hA5A5A502 || bus.Address !== 8'h03 || bus.InstrValid !== 1'b1) begin errors++;
        $display("FAIL stall_%0d: pc %h instr %h addr %h valid %b want 02/A5A5A502/03/1", i, bus.PCOut, bus.InstrOut, bus.Address, bus.InstrValid); end
      checks++; if (bus.FetchCount !== 16'd2) begin errors++; $display("FAIL stall_count_%0d: got %0d want 2", i, bus.FetchCount); end
    end
    bus.InstrReady = 1'b1;
    step();
    checks++; if (bus.PCOut !== 8'h03 || bus.FetchCount !== 16'd3 || bus.Address !== 8'h04) begin errors++;
      $display("FAIL stall_release: pc %h count %0d addr %h want 03/3/04", bus.PCOut, bus.FetchCount, bus.Address); end
  endtask

  task automatic test_halt();
    step(); step();
    checks++; if (bus.PCOut !== 8'h05 || bus.Address !== 8'h06) begin errors++;
      $display("FAIL pre_halt: pc %h addr %h want 05/06", bus.PCOut, bus.Address); end
    step();
    checks++; if (bus.PCOut !== 8'h06 || bus.InstrOut !== 32'hFFFF_FFFF || bus.InstrValid !== 1'b1) begin errors++;
      $display("FAIL halt_deliver: pc %h instr %h valid %b want 06/FFFFFFFF/1", bus.PCOut, bus.InstrOut, bus.InstrValid); end
    checks++; if (bus.Halted !== 1'b1 || bus.Address !== 8'h07) begin errors++;
      $display("FAIL halt_state: halted %b addr %h want 1/07", bus.Halted, bus.Address); end
    step();
    checks++; if (bus.InstrValid !== 1'b0 || bus.FetchCount !== 16'd7 || bus.Address !== 8'h07) begin errors++;
      $display("FAIL halt_drain: valid %b count %0d addr %h want 0/7/07", bus.InstrValid, bus.FetchCount, bus.Address); end
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    checks++; if (bus.Halted !== 1'b1 || bus.InstrValid !== 1'b0 || bus.Address !== 8'h07) begin errors++;
      $display("FAIL halt_hold: halted %b valid %b addr %h want 1/0/07", bus.Halted, bus.InstrValid, bus.Address); end
    bus.BranchValid = 1'b1; bus.BranchTarget = 8'h10;
    step();
    bus.BranchValid = 1'b0;
    checks++; if (bus.Halted !== 1'b0 || bus.Address !== 8'h10 || bus.InstrValid !== 1'b0) begin errors++;
      $display("FAIL halt_redirect: halted %b addr %h valid %b want 0/10/0", bus.Halted, bus.Address, bus.InstrValid); end
    step();
    checks++; if (bus.InstrValid !== 1'b1 || bus.PCOut !== 8'h10 || bus.InstrOut !== 32'hA5A5A510 || bus.FetchCount !== 16'd7) begin errors++;
      $display("FAIL halt_resume: valid %b pc %h instr %h count %0d want 1/10/A5A5A510/7", bus.InstrValid, bus.PCOut, bus.InstrOut, bus.FetchCount); end
  endtask

  task automatic test_flush_wrap();
    bus.InstrReady = 1'b0;
    step();
    bus.BranchValid = 1'b1; bus.BranchTarget = 8'hFE;
    step();
    bus.BranchValid = 1'b0; bus.InstrReady = 1'b1;
    checks++; if (bus.InstrValid !== 1'b0 || bus.Address !== 8'hFE || bus.FetchCount !== 16'd7) begin errors++;
      $display("FAIL flush: valid %b addr %h count %0d want 0/FE/7", bus.InstrValid, bus.Address, bus.FetchCount); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] pc;
      pc = 8'hFE + 8'(i);
      step();
      checks++; if (bus.InstrValid !== 1'b1 || bus.PCOut !== pc || bus.InstrOut !== {24'hA5A5A5, pc} || bus.FetchCount !== 16'(7 + i)) begin errors++;
        $display("FAIL wrap_%0d: valid %b pc %h instr %h count %0d want 1/%h/%h/%0d", i, bus.InstrValid, bus.PCOut, bus.InstrOut, bus.FetchCount, pc, {24'hA5A5A5, pc}, 7 + i); end
    end
    checks++; if (bus.Address !== 8'h01) begin errors++; $display("FAIL wrap_addr: got %h want 01", bus.Address); end
  endtask

  task automatic test_branch_with_transfer();
    bus.BranchValid = 1'b1; bus.BranchTarget = 8'h03;
    step();
    bus.BranchValid = 1'b0;
    checks++; if (bus.FetchCount !== 16'd10 || bus.InstrValid !== 1'b0 || bus.Address !== 8'h03) begin errors++;
      $display("FAIL branch_xfer: count %0d valid %b addr %h want 10/0/03", bus.FetchCount, bus.InstrValid, bus.Address); end
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    checks++; if (bus.InstrValid !== 1'b1 || bus.PCOut !== 8'h03 || bus.Address !== 8'h04) begin errors++;
      $display("FAIL start_in_fetch: valid %b pc %h addr %h want 1/03/04", bus.InstrValid, bus.PCOut, bus.Address); end
  endtask

  task automatic test_reset_mid_stall();
    bus.InstrReady = 1'b0;
    step();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1; bus.InstrReady = 1'b1;
    checks++; if (bus.InstrValid !== 1'b0 || bus.FetchCount !== 16'h0 || bus.Address !== 8'h00 || bus.PCOut !== 8'h00 || bus.InstrOut !== 32'h0) begin errors++;
      $display("FAIL mid_reset: valid %b count %0d addr %h pc %h instr %h want 0/0/00/00/0", bus.InstrValid, bus.FetchCount, bus.Address, bus.PCOut, bus.InstrOut); end
    step(); step();
    checks++; if (bus.InstrValid !== 1'b0 || bus.Address !== 8'h00) begin errors++;
      $display("FAIL mid_reset_idle: valid %b addr %h want 0/00", bus.InstrValid, bus.Address); end
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    checks++; if (bus.InstrValid !== 1'b1 || bus.PCOut !== 8'h00 || bus.FetchCount !== 16'd0) begin errors++;
      $display("FAIL restart: valid %b pc %h count %0d want 1/00/0", bus.InstrValid, bus.PCOut, bus.FetchCount); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_halt();
    test_flush_wrap();
    test_branch_with_transfer();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
